// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared types and constants for the Harvard data-memory slice.
//            dmem_state_t : CLEAR (zero-fill after reset) / READY (serving)
//            WORD_BYTES   : bytes per memory word
// Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_t;

    localparam int WORD_BYTES = 4;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_data_ram_harvard_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_data_ram_harvard_if
// Purpose  : Data-memory bus between mips_cpu_harvard (master) and
//            mips_data_ram_harvard (slave).
//   data_address   32  byte address          (master -> slave)
//   data_write      1  write strobe          (master -> slave)
//   data_read       1  read strobe           (master -> slave)
//   data_writedata 32  write data            (master -> slave)
//   data_readdata  32  combinational read    (slave  -> master)
//   mem_ready       1  clear sequence done   (slave  -> master)
//   fault           1  sticky illegal access (slave  -> master)
//   fault_addr     32  first faulting addr   (slave  -> master)
//   rd_count/wr_count 32  accepted accesses, only with DMEM_STATS_EN
// Macro    : DMEM_STATS_EN adds rd_count / wr_count.
// Revision : 1.0  initial release
// ============================================================================
interface mips_data_ram_harvard_if;

    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        mem_ready;
    logic        fault;
    logic [31:0] fault_addr;
`ifdef DMEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    modport master (
        output data_address, data_write, data_read, data_writedata,
        input  data_readdata, mem_ready, fault, fault_addr
`ifdef DMEM_STATS_EN
        , input rd_count, wr_count
`endif
    );

    modport slave (
        input  data_address, data_write, data_read, data_writedata,
        output data_readdata, mem_ready, fault, fault_addr
`ifdef DMEM_STATS_EN
        , output rd_count, wr_count
`endif
    );

endinterface : mips_data_ram_harvard_if
`default_nettype wire

// File: rtl/mips_dmem_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : mips_dmem_addr_decode
// Purpose  : Combinational byte-address to word-index decode with range and
//            alignment classification relative to BASE_ADDR.
//   address      in  32      byte address from the CPU
//   index        out ADDR_W  word index into the RAM
//   legal        out 1       aligned and inside the window
//   misaligned   out 1       low address bits non-zero
//   out_of_range out 1       word offset >= 2**ADDR_W
// Revision : 1.0  initial release
// ============================================================================
module mips_dmem_addr_decode
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          ADDR_W    = 8
) (
    input  logic [31:0]       address,
    output logic [ADDR_W-1:0] index,
    output logic              legal,
    output logic              misaligned,
    output logic              out_of_range
);

    localparam int LSB = $clog2(WORD_BYTES);

    logic [31:0] w_offset;

    // Unsigned wrap: addresses below BASE_ADDR become huge offsets and are
    // therefore caught by the out-of-range test rather than needing a compare.
    assign w_offset     = address - BASE_ADDR;
    assign misaligned   = |w_offset[LSB-1:0];
    assign out_of_range = |w_offset[31:ADDR_W+LSB];
    assign index        = w_offset[ADDR_W+LSB-1:LSB];
    assign legal        = ~misaligned & ~out_of_range;

endmodule : mips_dmem_addr_decode
`default_nettype wire

// File: rtl/mips_data_ram_harvard.sv
`default_nettype none
// ============================================================================
// Module   : mips_data_ram_harvard
// Purpose  : Slave end of the Harvard data-memory bus. Word-addressed RAM with
//            synchronous write / combinational read, a zero-fill sequence after
//            reset, range/alignment checking and a sticky fault latch.
//   clk    in  1  clock, all state updates on posedge
//   reset  in  1  synchronous, active-high
//   bus    slave modport of mips_data_ram_harvard_if
// Macro    : DMEM_STATS_EN enables rd_count / wr_count accepted-access counters.
// Revision : 1.0  initial release
// ============================================================================
module mips_data_ram_harvard
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          ADDR_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_data_ram_harvard_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    dmem_state_t       r_state;
    dmem_state_t       w_state_next;
    logic              w_clear_we;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [31:0]       r_mem [DEPTH];
    logic              r_fault;
    logic [31:0]       r_fault_addr;

    logic [ADDR_W-1:0] w_index;
    logic              w_legal;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_active;
    logic              w_both;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_illegal;

    mips_dmem_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W)
    ) u_decode (
        .address      (bus.data_address),
        .index        (w_index),
        .legal        (w_legal),
        .misaligned   (w_misaligned),
        .out_of_range (w_out_of_range)
    );

    // Nothing is served while reset is asserted, even if the state register
    // still holds READY from before.
    assign w_active  = (r_state == READY) & ~reset;
    assign w_both    = bus.data_read & bus.data_write;
    assign w_rd_ok   = w_active & bus.data_read  & ~bus.data_write & w_legal;
    assign w_wr_ok   = w_active & bus.data_write & ~bus.data_read  & w_legal;
    assign w_illegal = w_active & (bus.data_read | bus.data_write)
                     & (w_misaligned | w_out_of_range | w_both);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear_we   = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clear_we = 1'b1;
                if (&r_clr_idx) begin
                    w_state_next = READY;
                end
            end
            READY: begin
                w_state_next = READY;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_idx <= '0;
        end else if (w_clear_we) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    // ---------------- Memory array ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_clear_we) begin
                r_mem[r_clr_idx] <= '0;
            end else if (w_wr_ok) begin
                r_mem[w_index] <= bus.data_writedata;
            end
        end
    end

    // Read returns the pre-edge contents, so a same-cycle write is not seen.
    assign bus.data_readdata = w_rd_ok ? r_mem[w_index] : 32'h0;
    assign bus.mem_ready     = (r_state == READY);

    // ---------------- Sticky fault latch ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else if (w_illegal && !r_fault) begin
            r_fault      <= 1'b1;
            r_fault_addr <= bus.data_address;
        end
    end

    assign bus.fault      = r_fault;
    assign bus.fault_addr = r_fault_addr;

`ifdef DMEM_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_rd_ok) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_wr_ok) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign bus.rd_count = r_rd_count;
    assign bus.wr_count = r_wr_count;
`endif

endmodule : mips_data_ram_harvard
`default_nettype wire

// File: tb/tb_mips_data_ram_harvard.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_data_ram_harvard
// Purpose  : Self-checking bench for mips_data_ram_harvard. Directed stimulus
//            pushes hand-computed expectations tagged with the cycle they apply
//            to; a negedge monitor pops and compares them.
// Macro    : DMEM_STATS_EN also checks rd_count / wr_count.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_data_ram_harvard;

    localparam int K_RD  = 0;
    localparam int K_RDY = 1;
    localparam int K_FLT = 2;
    localparam int K_FA  = 3;
    localparam int K_RC  = 4;
    localparam int K_WC  = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    exp_t e;
    logic [31:0] act;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_data_ram_harvard_if bus();

    mips_data_ram_harvard #(
        .BASE_ADDR (32'h0000_1000),
        .ADDR_W    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] actual(int kind);
        case (kind)
            K_RD:    return bus.data_readdata;
            K_RDY:   return {31'b0, bus.mem_ready};
            K_FLT:   return {31'b0, bus.fault};
            K_FA:    return bus.fault_addr;
`ifdef DMEM_STATS_EN
            K_RC:    return bus.rd_count;
            K_WC:    return bus.wr_count;
`endif
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            act = actual(e.kind);
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc=%0d actual=%h required=%h", e.name, e.cyc, act, e.exp);
            end
        end
    end

    task automatic expect_val(int kind, logic [31:0] v, string name);
        exp_t x;
        x.cyc  = cyc;
        x.kind = kind;
        x.exp  = v;
        x.name = name;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [31:0] addr, logic rd, logic wr, logic [31:0] wd);
        bus.data_address   = addr;
        bus.data_read      = rd;
        bus.data_write     = wr;
        bus.data_writedata = wd;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic expect_zeroed(string tag);
        expect_val(K_FLT, 32'h0, {tag, "_fault0"});
        expect_val(K_FA,  32'h0, {tag, "_faddr0"});
`ifdef DMEM_STATS_EN
        expect_val(K_RC,  32'h0, {tag, "_rc0"});
        expect_val(K_WC,  32'h0, {tag, "_wc0"});
`endif
    endtask

    // Called in the first cycle after reset drops; returns in the READY cycle.
    task automatic clear_sequence(string tag);
        for (int k = 0; k <= 256; k++) begin
            expect_val(K_RDY, 32'(k == 256), {tag, "_mem_ready"});
            if (k == 0) expect_zeroed(tag);
            if (k == 5) begin
                drive(32'h0000_1000, 1'b1, 1'b0, 32'h0);
                expect_val(K_RD, 32'h0, {tag, "_rd_in_clear"});
            end
            if (k == 6) idle();
            if (k < 256) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        #1;
        expect_val(K_RD, 32'h0, "rd_in_reset");
        step();
        reset = 1'b0;

        // 1: clear timing, then every word reads zero
        clear_sequence("t1");
        n_tests++;
        if (bus.mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_direct_ready actual=%b required=1", bus.mem_ready);
        end
        for (int i = 0; i < 256; i++) begin
            drive(32'h0000_1000 + 32'(4 * i), 1'b1, 1'b0, 32'h0);
            expect_val(K_RD, 32'h0, "t1_read_zero");
            step();
        end

        // 2: write then read back
        drive(32'h0000_1004, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'h0, "t2_pre_read_old");
        step();
        drive(32'h0000_1004, 1'b0, 1'b1, 32'hDEAD_BEEF);
        expect_val(K_RD, 32'h0, "t2_write_cycle_rd");
        step();
        drive(32'h0000_1004, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'hDEAD_BEEF, "t2_read_new");
        #1;
        n_tests++;
        if (bus.data_readdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL t2_direct_read actual=%h required=deadbeef", bus.data_readdata);
        end
        step();
        drive(32'h0000_13F8, 1'b0, 1'b1, 32'h1234_5678);
        step();
        drive(32'h0000_1000, 1'b0, 1'b1, 32'hA5A5_A5A5);
        step();
        drive(32'h0000_13F8, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'h1234_5678, "t2_read_13f8");
        step();
        drive(32'h0000_1000, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'hA5A5_A5A5, "t2_read_1000");
        step();
        idle();
        expect_val(K_FLT, 32'h0, "t2_no_fault");
        expect_val(K_FA,  32'h0, "t2_no_faddr");
        step();

        // 3: misaligned read latches fault; later faults keep first address
        drive(32'h0000_1002, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'h0, "t3_misaligned_rd");
        step();
        idle();
        expect_val(K_FLT, 32'h1, "t3_fault_set");
        expect_val(K_FA,  32'h0000_1002, "t3_faddr");
        n_tests++;
        if (bus.fault !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_direct_fault actual=%b required=1", bus.fault);
        end
        n_tests++;
        if (bus.fault_addr !== 32'h0000_1002) begin
            n_fail++;
            $display("FAIL t3_direct_faddr actual=%h required=00001002", bus.fault_addr);
        end
        step();
        drive(32'h0000_1400, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'h0, "t3_oor_rd");
        step();
        idle();
        expect_val(K_FLT, 32'h1, "t3_fault_sticky");
        expect_val(K_FA,  32'h0000_1002, "t3_faddr_kept");
        step();

        // 4: out-of-range writes are suppressed
        drive(32'h0000_0FFC, 1'b0, 1'b1, 32'hFFFF_FFFF);
        step();
        drive(32'h0000_1400, 1'b0, 1'b1, 32'hFFFF_FFFF);
        step();
        drive(32'h0000_13FC, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'h0, "t4_13fc_unchanged");
        step();
        drive(32'h0000_1000, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'hA5A5_A5A5, "t4_1000_unchanged");
        expect_val(K_FLT, 32'h1, "t4_fault");
        step();

        // 5: simultaneous read and write is illegal
        drive(32'h0000_1008, 1'b1, 1'b1, 32'h0000_0001);
        expect_val(K_RD, 32'h0, "t5_both_rd");
        step();
        drive(32'h0000_1008, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'h0, "t5_mem2_unchanged");
        expect_val(K_FLT, 32'h1, "t5_fault");
        n_tests++;
        if (bus.fault !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_direct_fault actual=%b required=1", bus.fault);
        end
        step();

        // 6: fresh reset, counted accesses, then reset in the middle of clear
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        clear_sequence("t6a");
        drive(32'h0000_1000, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'h0, "t6_rd0");
        step();
        drive(32'h0000_1004, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'h0, "t6_rd1");
        step();
        drive(32'h0000_1008, 1'b0, 1'b1, 32'h0000_0077);
        step();
        drive(32'h0000_100C, 1'b0, 1'b1, 32'h0000_0088);
        step();
        drive(32'h0000_1008, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'h0000_0077, "t6_rd2");
        step();
        drive(32'h0000_1001, 1'b1, 1'b0, 32'h0);
        expect_val(K_RD, 32'h0, "t6_illegal_rd");
        step();
        idle();
        expect_val(K_FLT, 32'h1, "t6_fault");
        expect_val(K_FA,  32'h0000_1001, "t6_faddr");
`ifdef DMEM_STATS_EN
        expect_val(K_RC, 32'd3, "t6_rd_count");
        expect_val(K_WC, 32'd2, "t6_wr_count");
`endif
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            expect_val(K_RDY, 32'h0, "t6b_mem_ready");
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_sequence("t6c");

        idle();
        step();
        step();
        while (q.size() != 0) begin
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s unchecked actual=none required=%h", e.name, e.exp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mips_data_ram_harvard
`default_nettype wire
